// File: rtl/rob_retire.sv
// rob_retire
// In-order commit stage sitting directly after the reorder buffer. Each cycle
// it looks at up to EXT_COUNT head entries and retires the longest legal
// prefix, acknowledging the ROB combinationally. It issues registered
// register-file writes, offers at most one store per cycle to the store
// buffer, and stops for good once a halt commits. Killed entries drain
// without any architectural effect.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   slot_*                per-head-entry status, data and kind flags
//   consume               retire this cycle (combinational)
//   consume_count         entries retired minus one (combinational)
//   rf_we/waddr/wdata     register-file write ports (registered, 1 cycle)
//   sb_valid/addr/data    store offered to the store buffer (registered)
//   sb_ready              store buffer accepts when sb_valid && sb_ready
//   halted                a halt has committed
//   retired_count         running count of non-killed retired entries
//
// State | Meaning
// ------+--------------------------------------------------------------
// RUN   | normal operation, retire groups are formed every cycle
// HALTED| a halt committed; nothing retires until reset
module rob_retire #(
    parameter int EXT_COUNT    = 4,
    parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [EXT_COUNT-1:0]            slot_valid,
    input  logic [EXT_COUNT-1:0]            slot_kill,
    input  logic [EXT_COUNT-1:0][4:0]       slot_dest_reg,
    input  logic [EXT_COUNT-1:0]            slot_dest_reg_valid,
    input  logic [EXT_COUNT-1:0][31:0]      slot_result,
    input  logic [EXT_COUNT-1:0]            slot_is_store,
    input  logic [EXT_COUNT-1:0][31:0]      slot_store_addr,
    input  logic [EXT_COUNT-1:0]            slot_is_halt,
    output logic                            consume,
    output logic [EXTCOUNTLOG2-1:0]         consume_count,
    output logic [EXT_COUNT-1:0]            rf_we,
    output logic [EXT_COUNT-1:0][4:0]       rf_waddr,
    output logic [EXT_COUNT-1:0][31:0]      rf_wdata,
    output logic                            sb_valid,
    output logic [31:0]                     sb_addr,
    output logic [31:0]                     sb_data,
    input  logic                            sb_ready,
    output logic                            halted,
    output logic [31:0]                     retired_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;

    logic [EXT_COUNT-1:0]    take;
    logic [EXT_COUNT-1:0]    we_next;
    logic                    store_take;
    logic [EXTCOUNTLOG2-1:0] store_idx;
    logic                    halt_take;
    logic [EXTCOUNTLOG2:0]   group_size;
    logic [EXTCOUNTLOG2:0]   live_size;
    logic                    store_free;

    // The store slot is usable if empty or being emptied on this very edge.
    assign store_free = !sb_valid || sb_ready;

    // Prefix scan: once any entry refuses to join, nothing younger may join.
    always_comb begin
        logic stop;
        take       = '0;
        store_take = 1'b0;
        store_idx  = '0;
        halt_take  = 1'b0;
        group_size = '0;
        live_size  = '0;
        // Reset gating keeps consume low while reset is held.
        stop       = (state != RUN) || reset;
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (!stop) begin
                if (!slot_valid[i]) begin
                    stop = 1'b1;
                end else if (slot_kill[i]) begin
                    take[i]    = 1'b1;
                    group_size = group_size + 1'b1;
                end else if (slot_is_store[i] && (store_take || !store_free)) begin
                    stop = 1'b1;
                end else begin
                    take[i]    = 1'b1;
                    group_size = group_size + 1'b1;
                    live_size  = live_size + 1'b1;
                    if (slot_is_store[i]) begin
                        store_take = 1'b1;
                        store_idx  = EXTCOUNTLOG2'(i);
                    end
                    if (slot_is_halt[i]) begin
                        halt_take = 1'b1;
                        stop      = 1'b1;
                    end
                end
            end
        end
    end

    assign consume       = (group_size != '0);
    assign consume_count = (group_size == '0) ? '0
                                              : EXTCOUNTLOG2'(group_size - 1'b1);

    // A write is enabled only if no younger live group member targets the
    // same register, so each register number reaches at most one port.
    always_comb begin
        for (int i = 0; i < EXT_COUNT; i++) begin
            we_next[i] = take[i] && !slot_kill[i] && slot_dest_reg_valid[i]
                         && (slot_dest_reg[i] != 5'd0);
            for (int j = 0; j < EXT_COUNT; j++) begin
                if ((j > i) && take[j] && !slot_kill[j] && slot_dest_reg_valid[j]
                    && (slot_dest_reg[j] == slot_dest_reg[i])) begin
                    we_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            halted        <= 1'b0;
            rf_we         <= '0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            sb_valid      <= 1'b0;
            sb_addr       <= '0;
            sb_data       <= '0;
            retired_count <= '0;
        end else begin
            rf_we <= we_next;
            for (int i = 0; i < EXT_COUNT; i++) begin
                rf_waddr[i] <= we_next[i] ? slot_dest_reg[i] : 5'd0;
                rf_wdata[i] <= we_next[i] ? slot_result[i]   : 32'd0;
            end

            // A new store may retire on the same edge the old one is accepted.
            if (store_take) begin
                sb_valid <= 1'b1;
                sb_addr  <= slot_store_addr[store_idx];
                sb_data  <= slot_result[store_idx];
            end else if (sb_valid && sb_ready) begin
                sb_valid <= 1'b0;
            end

            retired_count <= retired_count + 32'(live_size);

            case (state)
                RUN: begin
                    if (halt_take) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
module tb_rob_retire;

    localparam int N = 4;

    logic                clock;
    logic                reset;
    logic [N-1:0]        slot_valid, slot_kill, slot_dest_reg_valid;
    logic [N-1:0]        slot_is_store, slot_is_halt;
    logic [N-1:0][4:0]   slot_dest_reg;
    logic [N-1:0][31:0]  slot_result, slot_store_addr;
    logic                consume;
    logic [1:0]          consume_count;
    logic [N-1:0]        rf_we;
    logic [N-1:0][4:0]   rf_waddr;
    logic [N-1:0][31:0]  rf_wdata;
    logic                sb_valid, sb_ready, halted;
    logic [31:0]         sb_addr, sb_data, retired_count;

    rob_retire #(.EXT_COUNT(N)) dut (
        .clock(clock), .reset(reset),
        .slot_valid(slot_valid), .slot_kill(slot_kill),
        .slot_dest_reg(slot_dest_reg), .slot_dest_reg_valid(slot_dest_reg_valid),
        .slot_result(slot_result), .slot_is_store(slot_is_store),
        .slot_store_addr(slot_store_addr), .slot_is_halt(slot_is_halt),
        .consume(consume), .consume_count(consume_count),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_valid(sb_valid), .sb_addr(sb_addr), .sb_data(sb_data),
        .sb_ready(sb_ready), .halted(halted), .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: what the registered outputs should currently show.
    logic                m_halted, m_sbv;
    logic [31:0]         m_sba, m_sbd, m_cnt;
    logic [N-1:0]        m_we;
    logic [N-1:0][4:0]   m_wa;
    logic [N-1:0][31:0]  m_wd;

    typedef struct {
        logic              rst;
        logic [3:0]        v, k, dv, st, ht;
        logic [3:0][4:0]   d;
        logic [3:0][31:0]  r;
        logic [3:0][31:0]  a;
        logic              rdy;
        logic              ec;
        logic [1:0]        ecc;
    } vec_t;

    vec_t tab[16];

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] k, logic [3:0] dv,
                                logic [3:0] st, logic [3:0] ht, logic [19:0] d,
                                logic [31:0] rbase, logic rdy, logic ec, logic [1:0] ecc);
        vec_t t;
        t.rst = rst; t.v = v; t.k = k; t.dv = dv; t.st = st; t.ht = ht;
        t.d = d; t.rdy = rdy; t.ec = ec; t.ecc = ecc;
        for (int i = 0; i < 4; i++) begin
            t.r[i] = rbase + 32'(i);
            t.a[i] = 32'h1000 + rbase + 32'(i * 4);
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        reset = t.rst; slot_valid = t.v; slot_kill = t.k; slot_dest_reg_valid = t.dv;
        slot_is_store = t.st; slot_is_halt = t.ht; slot_dest_reg = t.d;
        slot_result = t.r; slot_store_addr = t.a; sb_ready = t.rdy;
    endtask

    // Length of the legal retire prefix under the commit rules.
    function automatic int grp_size();
        int  n = 0;
        bit  has_st = 0;
        if (reset || m_halted) return 0;
        for (int i = 0; i < N; i++) begin
            if (!slot_valid[i]) break;
            if (!slot_kill[i] && slot_is_store[i] && (has_st || (m_sbv && !sb_ready))) break;
            n = i + 1;
            if (!slot_kill[i] && slot_is_store[i]) has_st = 1;
            if (!slot_kill[i] && slot_is_halt[i]) break;
        end
        return n;
    endfunction

    task automatic model_update(input int n);
        logic [31:0] seen;
        if (reset) begin
            m_halted = 0; m_sbv = 0; m_sba = 0; m_sbd = 0; m_cnt = 0;
            m_we = '0; m_wa = '0; m_wd = '0;
            return;
        end
        m_we = '0; m_wa = '0; m_wd = '0; seen = '0;
        // Walk youngest to oldest: the first writer seen for a register wins.
        for (int i = n - 1; i >= 0; i--) begin
            if (!slot_kill[i] && slot_dest_reg_valid[i] && slot_dest_reg[i] != 0
                && !seen[slot_dest_reg[i]]) begin
                m_we[i] = 1; m_wa[i] = slot_dest_reg[i]; m_wd[i] = slot_result[i];
            end
            if (!slot_kill[i] && slot_dest_reg_valid[i]) seen[slot_dest_reg[i]] = 1;
        end
        begin
            bit st_done = 0;
            for (int i = 0; i < n; i++) begin
                if (!slot_kill[i]) m_cnt = m_cnt + 1;
                if (!slot_kill[i] && slot_is_store[i]) begin
                    m_sbv = 1; m_sba = slot_store_addr[i]; m_sbd = slot_result[i]; st_done = 1;
                end
                if (!slot_kill[i] && slot_is_halt[i]) m_halted = 1;
            end
            if (!st_done && m_sbv && sb_ready && !(n == 0 && 0)) begin
                m_sbv = 0;
            end
        end
    endtask

    task automatic run_cycle(input bit use_tab, input logic ec, input logic [1:0] ecc,
                             input string tag);
        int n;
        @(negedge clock);
        n = grp_size();
        if (use_tab) begin
            chk({tag, ".tab_consume"}, 128'(consume), 128'(ec));
            chk({tag, ".tab_count"}, 128'(consume_count), 128'(ecc));
        end
        chk({tag, ".consume"}, 128'(consume), 128'(n > 0));
        chk({tag, ".count"}, 128'(consume_count), 128'(n > 0 ? n - 1 : 0));
        chk({tag, ".rf_we"}, 128'(rf_we), 128'(m_we));
        chk({tag, ".rf_waddr"}, 128'(rf_waddr), 128'(m_wa));
        chk({tag, ".rf_wdata"}, 128'(rf_wdata), 128'(m_wd));
        chk({tag, ".sb_valid"}, 128'(sb_valid), 128'(m_sbv));
        chk({tag, ".sb_addr"}, 128'(sb_addr), 128'(m_sba));
        chk({tag, ".sb_data"}, 128'(sb_data), 128'(m_sbd));
        chk({tag, ".halted"}, 128'(halted), 128'(m_halted));
        chk({tag, ".retired"}, 128'(retired_count), 128'(m_cnt));
        @(posedge clock);
        #1;
        model_update(n);
    endtask

    initial begin
        // Test-plan vectors, applied in order; the model tracks state between them.
        tab[0]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0, 32'h0, 1, 0, 0);
        tab[1]  = mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
                     {5'd4, 5'd3, 5'd2, 5'd1}, 32'h10, 1, 1, 3);
        tab[2]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0, 32'h0, 1, 0, 0);
        tab[3]  = mk(0, 4'b1011, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
                     {5'd4, 5'd3, 5'd2, 5'd0}, 32'h20, 1, 1, 1);
        tab[4]  = mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
                     {5'd7, 5'd5, 5'd6, 5'd5}, 32'h30, 1, 1, 3);
        tab[4].r[0] = 32'hA;
        tab[4].r[2] = 32'hB;
        tab[5]  = mk(0, 4'b1111, 4'b0000, 4'b0001, 4'b0110, 4'b0000,
                     {5'd0, 5'd0, 5'd0, 5'd9}, 32'h40, 0, 1, 1);
        tab[6]  = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, '0, 32'h50, 0, 0, 0);
        tab[7]  = tab[6];
        tab[8]  = tab[6];
        tab[9]  = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, '0, 32'h50, 1, 1, 3);
        tab[10] = mk(0, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 4'b1000,
                     {5'd1, 5'd2, 5'd3, 5'd4}, 32'h60, 1, 1, 3);
        tab[11] = mk(0, 4'b1111, 4'b0000, 4'b1110, 4'b0001, 4'b0010,
                     {5'd3, 5'd2, 5'd1, 5'd0}, 32'h70, 0, 1, 1);
        tab[12] = mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
                     {5'd4, 5'd3, 5'd2, 5'd1}, 32'h80, 0, 0, 0);
        tab[13] = mk(1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
                     {5'd4, 5'd3, 5'd2, 5'd1}, 32'h90, 1, 0, 0);
        tab[14] = mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
                     {5'd4, 5'd3, 5'd2, 5'd1}, 32'hA0, 1, 1, 3);
        tab[15] = tab[0];

        apply(tab[0]);
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        model_update(0);
        reset = 0;

        for (int t = 0; t < 16; t++) begin
            apply(tab[t]);
            run_cycle(1, tab[t].ec, tab[t].ecc, $sformatf("vec%0d", t));
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            reset               = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
            slot_valid          = 4'($urandom);
            slot_kill           = 4'($urandom) & 4'($urandom);
            slot_dest_reg_valid = 4'($urandom);
            slot_is_store       = 4'($urandom) & 4'($urandom);
            sb_ready            = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                slot_is_halt[i]    = ($urandom_range(0, 24) == 0);
                slot_dest_reg[i]   = 5'($urandom_range(0, 5));
                slot_result[i]     = $urandom;
                slot_store_addr[i] = $urandom;
            end
            run_cycle(0, 1'b0, 2'd0, $sformatf("rnd%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
